// File: rtl/cache_pkg.sv
// cache_pkg: op codes, FSM state encoding and sizing helper shared by the
// set-associative cache and its LRU tracker.
package cache_pkg;
  localparam int CACHE_OP_TYPE_WIDTH = 2;
  localparam logic [CACHE_OP_TYPE_WIDTH-1:0] CACHE_OP_BYTE = 2'd0;
  localparam logic [CACHE_OP_TYPE_WIDTH-1:0] CACHE_OP_WORD = 2'd1;
  localparam logic [CACHE_OP_TYPE_WIDTH-1:0] CACHE_OP_LINE = 2'd2;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WRITEBACK, ST_REFILL_REQ, ST_REFILL_WAIT, ST_RESPOND
  } cache_state_e;
  function automatic int clog2(input int n);
    clog2 = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) clog2 = i + 1;
  endfunction
endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set true-LRU ages; the touched way becomes youngest and ways
// younger than its old age shift one step older, so ages stay a permutation.
module cache_lru import cache_pkg::*; #(
  parameter int WAYS = 2,
  parameter int SETS = 4,
  localparam int WAY_W = WAYS > 1 ? clog2(WAYS) : 1,
  localparam int IDX_W = clog2(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_touch,
  input  logic [IDX_W-1:0] i_set,
  input  logic [WAY_W-1:0] i_way,
  output logic [WAY_W-1:0] o_victim
);
  logic [WAY_W-1:0] r_age [SETS][WAYS];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
    end else if (i_touch) begin
      for (int w = 0; w < WAYS; w++)
        r_age[i_set][w] <= WAY_W'(w) == i_way ? '0 :
                           r_age[i_set][w] < r_age[i_set][i_way] ? r_age[i_set][w] + 1'b1 :
                           r_age[i_set][w];
    end
  always_comb begin
    o_victim = '0;
    for (int w = 0; w < WAYS; w++) if (r_age[i_set][w] == WAY_W'(WAYS - 1)) o_victim = WAY_W'(w);
  end
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back/write-allocate cache with
// true-LRU replacement and a single-outstanding miss-handling FSM.
module assoc_cache import cache_pkg::*; #(
  parameter int ADDR_WIDTH = 20,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 4,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [LINE_BYTES*8-1:0] resp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [LINE_BYTES*8-1:0] mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_resp_rdata
);
  localparam int LB    = LINE_BYTES * 8;
  localparam int OFF_W = clog2(LINE_BYTES);
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W = WAYS > 1 ? clog2(WAYS) : 1;

  cache_state_e          r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_op;
  logic                  r_write;
  logic [LB-1:0]         r_wdata, r_rdata, w_base, w_line;
  logic [WAY_W-1:0]      r_way, w_way, w_hit_way, w_free_way, w_lru_way, w_vict;
  logic                  r_valid [SETS][WAYS];
  logic                  r_dirty [SETS][WAYS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [LB-1:0]         r_data  [SETS][WAYS];
  logic                  w_hit, w_free, w_acc, w_inv, w_full;
  logic [OFF_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;

  function automatic logic [LB-1:0] rd_sel(input logic [LB-1:0] l, input logic [1:0] op,
                                           input logic [OFF_W-1:0] off);
    rd_sel = op == CACHE_OP_BYTE ? LB'(l[{off, 3'b0} +: 8]) :
             op == CACHE_OP_WORD ? LB'(l[{off[OFF_W-1:2], 5'b0} +: 32]) : l;
  endfunction

  function automatic logic [LB-1:0] merge(input logic [LB-1:0] l, input logic [LB-1:0] d,
                                          input logic [1:0] op, input logic [OFF_W-1:0] off);
    merge = l;
    if (op == CACHE_OP_BYTE) merge[{off, 3'b0} +: 8] = d[7:0];
    else if (op == CACHE_OP_WORD) merge[{off[OFF_W-1:2], 5'b0} +: 32] = d[31:0];
    else merge = d;
  endfunction

  assign w_off  = r_addr[OFF_W-1:0];
  assign w_idx  = r_addr[OFF_W +: IDX_W];
  assign w_tag  = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_full = r_write && r_op == CACHE_OP_LINE;
  assign w_vict = w_free ? w_free_way : w_lru_way;
  assign w_line = r_write ? merge(w_base, r_wdata, r_op, w_off) : w_base;

  // Descending scan so the lowest-index match / free way wins.
  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    w_free = 1'b0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_free = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_acc  = 1'b0;
    w_inv  = 1'b0;
    w_way  = r_way;
    w_base = mem_resp_rdata;
    case (r_state)
      ST_IDLE: w_next = req_valid ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: begin
        w_way  = w_hit ? w_hit_way : w_vict;
        w_base = w_hit ? r_data[w_idx][w_hit_way] : r_wdata;
        w_acc  = w_hit || (!(r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) && w_full);
        w_next = w_acc ? ST_RESPOND :
                 r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict] ? ST_WRITEBACK : ST_REFILL_REQ;
      end
      ST_WRITEBACK: begin
        w_inv  = mem_req_ready;
        w_acc  = mem_req_ready && w_full;
        w_next = !mem_req_ready ? ST_WRITEBACK : w_full ? ST_RESPOND : ST_REFILL_REQ;
      end
      ST_REFILL_REQ:  w_next = mem_req_ready ? ST_REFILL_WAIT : ST_REFILL_REQ;
      ST_REFILL_WAIT: begin
        w_acc  = mem_resp_valid;
        w_next = mem_resp_valid ? ST_RESPOND : ST_REFILL_WAIT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_op    <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_way   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_op    <= req_op;
        r_write <= req_write;
        r_wdata <= req_wdata;
      end
      if (r_state == ST_LOOKUP) r_way <= w_way;
      if (w_inv) r_valid[w_idx][r_way] <= 1'b0;
      if (w_acc) begin
        r_valid[w_idx][w_way] <= 1'b1;
        r_dirty[w_idx][w_way] <= r_write || (w_hit && r_dirty[w_idx][w_way]);
        r_rdata <= r_write ? '0 : rd_sel(w_base, r_op, w_off);
      end
    end

  always_ff @(posedge clk)
    if (w_acc) begin
      r_data[w_idx][w_way] <= w_line;
      r_tag[w_idx][w_way]  <= w_tag;
    end

  cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk(clk), .reset(reset), .i_touch(w_acc), .i_set(w_idx), .i_way(w_way), .o_victim(w_lru_way)
  );

  assign req_ready     = r_state == ST_IDLE;
  assign resp_valid    = r_state == ST_RESPOND;
  assign resp_rdata    = r_rdata;
  assign mem_req_valid = r_state == ST_WRITEBACK || r_state == ST_REFILL_REQ;
  assign mem_req_write = r_state == ST_WRITEBACK;
  assign mem_req_addr  = {r_state == ST_WRITEBACK ? r_tag[w_idx][r_way] : w_tag, w_idx, OFF_W'(0)};
  assign mem_req_wdata = r_data[w_idx][r_way];
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed hit/miss/eviction/stall/reset sequence with
// hand-computed expectations checked by immediate assertions.
module tb_assoc_cache;
  import cache_pkg::*;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid, req_ready, req_write, resp_valid;
  logic [1:0] req_op;
  logic [19:0] req_addr, mem_req_addr;
  logic [127:0] req_wdata, resp_rdata, mem_req_wdata, mem_resp_rdata;
  logic mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
  int checks = 0, errors = 0;
  int nreq, lat;
  logic [127:0] got;
  logic [19:0] log_addr [4];
  logic log_wr [4];
  logic [127:0] log_wdata [4];

  localparam logic [127:0] L1 = 128'h00000000_00000000_DEADBEEF_00000000;
  localparam logic [127:0] L1M = 128'h00000000_00000000_DEADABEF_00000000;
  localparam logic [127:0] L2 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L3 = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
  localparam logic [127:0] L4 = 128'h55555555_66666666_77777777_12345678;
  localparam logic [127:0] L5 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
  localparam logic [127:0] LS = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and plays the memory side until the response (bounded).
  task automatic access(input logic w, input logic [1:0] op, input logic [19:0] a,
                        input logic [127:0] d, input logic [127:0] fill, input int stall);
    int left;
    logic pend, done;
    left = stall; pend = 1'b0; done = 1'b0; nreq = 0; lat = 0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_op = op; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      mem_req_ready = 1'b0; mem_resp_valid = pend; mem_resp_rdata = fill; pend = 1'b0;
      if (resp_valid) begin
        done = 1'b1; lat = n; got = resp_rdata;
      end else if (mem_req_valid && !mem_req_write && left > 0) begin
        left--;
        chk("stall_addr", mem_req_addr, a & 20'hFFFF0);
        chk("stall_req_ready", req_ready, 0);
      end else if (mem_req_valid) begin
        if (nreq < 4) begin
          log_addr[nreq] = mem_req_addr; log_wr[nreq] = mem_req_write; log_wdata[nreq] = mem_req_wdata;
        end
        nreq++;
        mem_req_ready = 1'b1;
        pend = !mem_req_write;
      end
      if (!done) @(negedge clk);
    end
    if (!done) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    req_valid = 0; req_write = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    reset = 1'b1;

    access(0, CACHE_OP_WORD, 20'h00104, 0, L1, 0);
    chk("cold_rdata", got, 128'hDEADBEEF); chk("cold_nreq", nreq, 1);
    chk("cold_addr", log_addr[0], 20'h00100); chk("cold_wr", log_wr[0], 0); chk("cold_lat", lat, 4);
    access(0, CACHE_OP_WORD, 20'h00104, 0, 0, 0);
    chk("hit_rdata", got, 128'hDEADBEEF); chk("hit_nreq", nreq, 0); chk("hit_lat", lat, 2);
    access(1, CACHE_OP_BYTE, 20'h00105, 128'hAB, 0, 0);
    chk("stb_rdata", got, 0); chk("stb_nreq", nreq, 0);
    access(0, CACHE_OP_BYTE, 20'h00105, 0, 0, 0);
    chk("ldb_rdata", got, 128'hAB);
    access(0, CACHE_OP_WORD, 20'h00104, 0, 0, 0);
    chk("ldw_merged", got, 128'hDEADABEF);

    access(0, CACHE_OP_WORD, 20'h00140, 0, L2, 0);
    chk("fill140_nreq", nreq, 1); chk("fill140_addr", log_addr[0], 20'h00140); chk("fill140_rdata", got, 128'h11111111);
    access(0, CACHE_OP_WORD, 20'h00100, 0, 0, 0);
    chk("touch100_nreq", nreq, 0); chk("touch100_rdata", got, 0);
    access(0, CACHE_OP_WORD, 20'h00180, 0, L3, 0);
    chk("evict_clean_nreq", nreq, 1); chk("evict_clean_wr", log_wr[0], 0);
    chk("evict_clean_addr", log_addr[0], 20'h00180); chk("evict_clean_rdata", got, 128'hCCCC0000);
    access(0, CACHE_OP_WORD, 20'h00140, 0, L2, 0);
    chk("wb_nreq", nreq, 2); chk("wb_wr", log_wr[0], 1); chk("wb_addr", log_addr[0], 20'h00100);
    chk("wb_wdata", log_wdata[0], L1M); chk("wb_fill_wr", log_wr[1], 0);
    chk("wb_fill_addr", log_addr[1], 20'h00140); chk("wb_rdata", got, 128'h11111111); chk("wb_lat", lat, 5);

    access(1, CACHE_OP_LINE, 20'h00200, LS, 0, 0);
    chk("linest_nreq", nreq, 0); chk("linest_lat", lat, 2);
    access(0, CACHE_OP_LINE, 20'h00200, 0, 0, 0);
    chk("lineld_rdata", got, LS); chk("lineld_nreq", nreq, 0);

    access(0, CACHE_OP_WORD, 20'h00184, 0, L3, 5);
    chk("stall_nreq", nreq, 1); chk("stall_fill_addr", log_addr[0], 20'h00180);
    chk("stall_rdata", got, 128'hCCCC0001); chk("stall_lat", lat, 9);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_op = CACHE_OP_WORD; req_addr = 20'h00010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rr_req_valid", mem_req_valid, 1); chk("rr_req_addr", mem_req_addr, 20'h00010);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rr_wait_req_valid", mem_req_valid, 0);
    #2 reset = 1'b0;
    #1 chk("rr_rst_resp_valid", resp_valid, 0);
    chk("rr_rst_mem_req_valid", mem_req_valid, 0);
    chk("rr_rst_req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = {128{1'b1}};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stray_resp_valid", resp_valid, 0); chk("stray_req_ready", req_ready, 1);
    access(0, CACHE_OP_WORD, 20'h00010, 0, L4, 0);
    chk("reload_nreq", nreq, 1); chk("reload_addr", log_addr[0], 20'h00010); chk("reload_rdata", got, 128'h12345678);
    access(0, CACHE_OP_LINE, 20'h00200, 0, L5, 0);
    chk("lost_dirty_nreq", nreq, 1); chk("lost_dirty_wr", log_wr[0], 0);
    chk("lost_dirty_addr", log_addr[0], 20'h00200); chk("lost_dirty_rdata", got, L5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
